// File: rtl/ir_fetch_unit_pkg.sv
// rtl/ir_fetch_unit_pkg.sv - shared FSM state type, fault NOP word and timer width for the IR fetch unit
package ir_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam int          TIMEOUT_DEFAULT  = 15;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'hD503201F;
  localparam int          TIMER_W          = $clog2(TIMEOUT_DEFAULT + 1);

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - cycle counter for outstanding memory requests
// expired flags the cycle whose increment would reach TIMEOUT, so the FSM leaves on that edge.
module fetch_timer
  import ir_fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/ir_fetch_unit.sv
// rtl/ir_fetch_unit.sv - instruction-register fetch FSM with misalignment, timeout and flush handling
module ir_fetch_unit
  import ir_fetch_unit_pkg::*;
#(
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic        busy,
  output logic        fault
);

  fetch_state_t state, state_next;

  logic accept;
  logic misaligned;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;
  logic ir_load_mem;
  logic ir_load_nop;

  assign misaligned = (pc_in[1:0] != 2'b00);

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    ir_load_mem = 1'b0;
    ir_load_nop = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_req && !flush) begin
          accept      = 1'b1;
          timer_clear = 1'b1;
          if (misaligned) begin
            ir_load_nop = 1'b1;
            state_next  = S_DONE;
          end else begin
            state_next  = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (flush) begin
            state_next  = S_IDLE;
          end else begin
            ir_load_mem = 1'b1;
            state_next  = S_DONE;
          end
        end else begin
          timer_en = 1'b1;
          // A flush landing on the timeout cycle has nothing left to drain.
          if (flush) begin
            state_next = timer_expired ? S_IDLE : S_DRAIN;
          end else if (timer_expired) begin
            ir_load_nop = 1'b1;
            state_next  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_ack) begin
          state_next = S_IDLE;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      IR       <= '0;
      mem_addr <= '0;
      fault    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        mem_addr <= pc_in;
      end
      if (ir_load_mem) begin
        IR <= mem_rdata;
      end else if (ir_load_nop) begin
        IR <= NOP_WORD;
      end
      if (ir_load_nop) begin
        fault <= 1'b1;
      end else if (accept) begin
        fault <= 1'b0;
      end
    end
  end

  assign mem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign ir_valid = (state == S_DONE) && !flush;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_ir_fetch_unit.sv
// tb/tb_ir_fetch_unit.sv - directed self-checking bench for ir_fetch_unit
module tb_ir_fetch_unit;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] pc_in;
  logic        flush;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] IR;
  logic        ir_valid;
  logic        busy;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt;

  ir_fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_req(fetch_req),
    .pc_in    (pc_in),
    .flush    (flush),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .IR       (IR),
    .ir_valid (ir_valid),
    .busy     (busy),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; pc_in = '0; flush = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) cyc();
    check("rst_ir", IR, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    rst = 1'b0;
    cyc();

    // basic fetch, ack one cycle after mem_req
    fetch_req = 1'b1; pc_in = 32'h40;
    cyc(); fetch_req = 1'b0; settle();
    check("basic_mem_req", mem_req, 1'b1);
    check("basic_addr", mem_addr, 32'h40);
    check("basic_busy", busy, 1'b1);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h8B020020; settle();
    check("basic_req_hold", mem_req, 1'b1);
    check("basic_no_valid_yet", ir_valid, 1'b0);
    cyc(); mem_ack = 1'b0; settle();
    check("basic_ir", IR, 32'h8B020020);
    check("basic_valid", ir_valid, 1'b1);
    check("basic_fault", fault, 1'b0);
    cyc();
    check("basic_valid_one_cycle", ir_valid, 1'b0);
    check("basic_idle", busy, 1'b0);

    // best-case latency: ack in the first REQ cycle
    fetch_req = 1'b1; pc_in = 32'h100;
    cyc(); fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11112222; settle();
    check("fast_mem_req", mem_req, 1'b1);
    cyc(); mem_ack = 1'b0; settle();
    check("fast_valid", ir_valid, 1'b1);
    check("fast_ir", IR, 32'h11112222);
    cyc();

    // timeout: mem_req held for exactly 15 cycles
    fetch_req = 1'b1; pc_in = 32'h200;
    cyc(); fetch_req = 1'b0; settle();
    req_cnt = 0;
    while (mem_req && req_cnt < 40) begin
      req_cnt++;
      cyc();
    end
    check("tmo_req_cycles", req_cnt, 15);
    check("tmo_ir", IR, NOP);
    check("tmo_fault", fault, 1'b1);
    check("tmo_valid", ir_valid, 1'b1);
    cyc();
    check("tmo_fault_sticky", fault, 1'b1);

    // next good fetch clears fault
    fetch_req = 1'b1; pc_in = 32'h300;
    cyc(); fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; settle();
    check("clr_fault", fault, 1'b0);
    cyc(); mem_ack = 1'b0; settle();
    check("clr_ir", IR, 32'hCAFEF00D);
    cyc();

    // misaligned: no memory access; fetch_req held through DONE must be ignored
    fetch_req = 1'b1; pc_in = 32'h42;
    cyc(); settle();
    check("mis_mem_req", mem_req, 1'b0);
    check("mis_ir", IR, NOP);
    check("mis_fault", fault, 1'b1);
    check("mis_valid", ir_valid, 1'b1);
    check("mis_addr", mem_addr, 32'h42);
    cyc(); fetch_req = 1'b0; settle();
    check("done_ignores_req", busy, 1'b0);
    check("mis_fault_sticky", fault, 1'b1);

    // flush in REQ, ack three cycles later
    fetch_req = 1'b1; pc_in = 32'h400;
    cyc(); fetch_req = 1'b0; flush = 1'b1; settle();
    check("fl_req_state", mem_req, 1'b1);
    cyc(); flush = 1'b0; settle();
    check("drain_mem_req", mem_req, 1'b1);
    check("drain_busy", busy, 1'b1);
    cyc();
    check("drain_mem_req2", mem_req, 1'b1);
    check("drain_no_valid", ir_valid, 1'b0);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
    check("drain_busy_at_ack", busy, 1'b1);
    cyc(); mem_ack = 1'b0; settle();
    check("drain_busy_drop", busy, 1'b0);
    check("drain_ir_kept", IR, NOP);
    check("drain_no_valid2", ir_valid, 1'b0);
    check("drain_no_fault", fault, 1'b0);

    // flush together with ack in REQ
    fetch_req = 1'b1; pc_in = 32'h500;
    cyc(); fetch_req = 1'b0; flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h12345678; settle();
    cyc(); flush = 1'b0; mem_ack = 1'b0; settle();
    check("flack_idle", busy, 1'b0);
    check("flack_ir_kept", IR, NOP);
    check("flack_no_valid", ir_valid, 1'b0);

    // flush in DONE suppresses ir_valid but IR keeps the new word
    fetch_req = 1'b1; pc_in = 32'h600;
    cyc(); fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0F0F0F0F; settle();
    cyc(); mem_ack = 1'b0; flush = 1'b1; settle();
    check("fldone_valid", ir_valid, 1'b0);
    check("fldone_ir", IR, 32'h0F0F0F0F);
    cyc(); flush = 1'b0; settle();
    check("fldone_idle", busy, 1'b0);

    // flush beats fetch_req in IDLE
    fetch_req = 1'b1; flush = 1'b1; pc_in = 32'h700;
    cyc(); fetch_req = 1'b0; flush = 1'b0; settle();
    check("flidle_mem_req", mem_req, 1'b0);
    check("flidle_busy", busy, 1'b0);
    check("flidle_addr", mem_addr, 32'h600);

    // ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
    cyc(); mem_ack = 1'b0; settle();
    check("idle_ack_ir", IR, 32'h0F0F0F0F);
    check("idle_ack_valid", ir_valid, 1'b0);

    // async reset mid-REQ, then a late ack
    fetch_req = 1'b1; pc_in = 32'h800;
    cyc(); fetch_req = 1'b0; settle();
    check("pre_rst_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_req", mem_req, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ir", IR, 32'h0);
    check("arst_addr", mem_addr, 32'h0);
    cyc(); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55555555;
    cyc(); mem_ack = 1'b0; settle();
    check("late_ack_ir", IR, 32'h0);
    check("late_ack_valid", ir_valid, 1'b0);
    check("late_ack_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
